uart_tx_arbiter: RTL

- Shares one uart_tx serializer among N_REQ byte requesters using round-robin arbitration with optional burst lock.
- Sits between requester blocks (FND/status reporters, command echo, etc.) and the uart_tx start/tx_data/tx_busy interface.
- Registers the granted byte and holds it stable for the whole frame, because uart_tx reads tx_data combinationally during DATA.
- Sequences start and waits for tx_busy to rise and then fall before serving the next byte.

---
 rtl/uart_arb_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the uart_tx request arbiter.
// Optional build macro: UART_ARB_FIXED_PRIO_EN (see uart_tx_arbiter).
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  localparam int N_REQ_DEF     = 4;
  localparam int MAX_BURST_DEF = 16;

  function automatic logic [2:0] oh_idx(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set bit at or above ptr_i,
// wrapping. Pointer is driven to zero by the top for fixed priority.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = N_REQ_DEF,
  parameter int PW = $clog2(N_REQ_DEF)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  win_o,
  output logic          valid_o
);

  int j;

  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!valid_o && req_i[j]) begin
        win_o[j] = 1'b1;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among N_REQ byte requesters with burst lock.
// UART_ARB_FIXED_PRIO_EN: lowest index wins instead of round-robin.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_last,
  input  logic [N_REQ*8-1:0] req_data,
  output logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   grant,
  output logic               uart_start,
  output logic [7:0]         uart_data,
  input  logic               uart_busy,
  output logic               arb_busy
);

  localparam int IW = $clog2(N_REQ);

  arb_state_e       state_q;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] ack_q;
  logic             start_q;
  logic [7:0]       data_q;
  logic             last_q;
  logic [7:0]       cnt_q;
  logic [IW-1:0]    own_q;

  logic [N_REQ-1:0] win;
  logic             win_vld;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    pick_ptr;
  logic             more;

`ifdef UART_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [IW-1:0] ptr_q;
  assign pick_ptr = ptr_q;
`endif

  rr_pick #(
    .N  (N_REQ),
    .PW (IW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (pick_ptr),
    .win_o   (win),
    .valid_o (win_vld)
  );

  assign win_idx = IW'(oh_idx(8'(win)));

  // Keep the lock only while the owner still offers a non-final byte.
  assign more = !last_q && req[own_q]
             && (cnt_q < 8'(MAX_BURST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
      cnt_q   <= 8'd0;
      own_q   <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      ack_q   <= '0;
      start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (win_vld) begin
            grant_q <= win;
            ack_q   <= win;
            data_q  <= req_data[8*win_idx +: 8];
            last_q  <= req_last[win_idx];
            cnt_q   <= 8'd1;
            own_q   <= win_idx;
            state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
          start_q <= 1'b1;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (uart_busy) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!uart_busy) begin
            if (more) begin
              ack_q   <= N_REQ'(1) << own_q;
              data_q  <= req_data[8*own_q +: 8];
              last_q  <= req_last[own_q];
              cnt_q   <= cnt_q + 8'd1;
              state_q <= LAUNCH;
            end else begin
              grant_q <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
              ptr_q   <= (own_q == IW'(N_REQ - 1))
                       ? '0 : own_q + 1'b1;
`endif
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ack    = ack_q;
  assign grant      = grant_q;
  assign uart_start = start_q;
  assign uart_data  = data_q;
  assign arb_busy   = (state_q != IDLE);

endmodule
